// File: rtl/half_adder_unit.sv
// rtl/half_adder_unit.sv - bit-wise half-adder lanes with a combinational result,
// a registered valid/ready copy and saturating accept/carry counters.
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  logic [WIDTH-1:0] r_s_q;
  logic [WIDTH-1:0] r_c_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_carry_cnt;

  logic             w_accept;
  logic             w_consume;
  logic             w_any_carry;
  logic             w_carry_inc;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_carry_next;

  assign s = a ^ b;
  assign c = a & b;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = r_out_valid && out_ready;
  assign w_any_carry = |(a & b);
  assign w_carry_inc = w_accept && w_any_carry;

  // A clear replaces the old count with this cycle's increment, so clear+accept yields 1.
  always_comb begin
    w_acc_next   = r_acc_cnt;
    w_carry_next = r_carry_cnt;
    if (clr_cnt) begin
      w_acc_next   = CNT_W'(w_accept);
      w_carry_next = CNT_W'(w_carry_inc);
    end else begin
      if (w_accept && !(&r_acc_cnt)) begin
        w_acc_next = r_acc_cnt + CNT_W'(1);
      end
      if (w_carry_inc && !(&r_carry_cnt)) begin
        w_carry_next = r_carry_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_q       <= '0;
      r_c_q       <= '0;
      r_out_valid <= 1'b0;
      r_acc_cnt   <= '0;
      r_carry_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_s_q       <= a ^ b;
        r_c_q       <= a & b;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      r_acc_cnt   <= w_acc_next;
      r_carry_cnt <= w_carry_next;
    end
  end

  assign s_q       = r_s_q;
  assign c_q       = r_c_q;
  assign out_valid = r_out_valid;
  assign acc_cnt   = r_acc_cnt;
  assign carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_half_adder_unit.sv
// tb/tb_half_adder_unit.sv - directed bench for half_adder_unit (WIDTH=1/CNT_W=4 and WIDTH=4).
module tb_half_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a = 1'b0, b = 1'b0;
  logic       s, c;
  logic       in_valid = 1'b0, in_ready;
  logic       s_q, c_q, out_valid;
  logic       out_ready = 1'b1;
  logic       clr_cnt = 1'b0;
  logic [3:0] acc_cnt, carry_cnt;

  logic [3:0]  a4 = 4'd0, b4 = 4'd0;
  logic [3:0]  s4, c4, s_q4, c_q4;
  logic        in_valid4 = 1'b0, in_ready4, out_valid4;
  logic        out_ready4 = 1'b1;
  logic        clr_cnt4 = 1'b0;
  logic [15:0] acc_cnt4, carry_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  half_adder_unit #(.WIDTH(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s), .c(c),
    .in_valid(in_valid), .in_ready(in_ready), .s_q(s_q), .c_q(c_q),
    .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt),
    .acc_cnt(acc_cnt), .carry_cnt(carry_cnt)
  );

  half_adder_unit #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .s(s4), .c(c4),
    .in_valid(in_valid4), .in_ready(in_ready4), .s_q(s_q4), .c_q(c_q4),
    .out_valid(out_valid4), .out_ready(out_ready4), .clr_cnt(clr_cnt4),
    .acc_cnt(acc_cnt4), .carry_cnt(carry_cnt4)
  );

  task automatic test_comb_sweep();
    logic [1:0] exp_sc [4];
    logic [1:0] ab_seq [4];
    ab_seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    exp_sc = '{2'b00, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      a = ab_seq[i][1];
      b = ab_seq[i][0];
      #10;
      n_tests++;
      if ({s, c} !== exp_sc[i]) begin
        n_fail++;
        $display("FAIL comb_sweep step %0d: s,c got %b,%b want %b,%b", i, s, c, exp_sc[i][1], exp_sc[i][0]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({out_valid, s_q, c_q} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_regs: out_valid,s_q,c_q got %b%b%b want 000", out_valid, s_q, c_q);
    end
    n_tests++;
    if (acc_cnt !== 4'd0 || carry_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: acc=%0d carry=%0d want 0 0", acc_cnt, carry_cnt);
    end
    n_tests++;
    if (in_ready !== 1'b1 || s !== 1'b0 || c !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_comb: in_ready=%b s=%b c=%b want 1 0 1", in_ready, s, c);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_registered();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = 1'b1; b = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, s_q, c_q} !== 3'b110) begin
      n_fail++;
      $display("FAIL reg_word1: out_valid,s_q,c_q got %b%b%b want 110", out_valid, s_q, c_q);
    end
    a = 1'b1; b = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, s_q, c_q} !== 3'b101) begin
      n_fail++;
      $display("FAIL reg_word2: out_valid,s_q,c_q got %b%b%b want 101", out_valid, s_q, c_q);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (acc_cnt !== 4'd2 || carry_cnt !== 4'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_counts: acc=%0d carry=%0d out_valid=%b want 2 1 0", acc_cnt, carry_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 1'b0; b = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 1'b1; b = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || s_q !== 1'b1 || c_q !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d of 5 cycles wrong, last in_ready=%b out_valid=%b s_q=%b c_q=%b want 0 1 1 0",
               bad, in_ready, out_valid, s_q, c_q);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready: in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, s_q, c_q} !== 3'b101) begin
      n_fail++;
      $display("FAIL bp_swap: out_valid,s_q,c_q got %b%b%b want 101", out_valid, s_q, c_q);
    end
    @(negedge clk);
    n_tests++;
    if (acc_cnt !== 4'd4 || carry_cnt !== 4'd2 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_counts: acc=%0d carry=%0d out_valid=%b want 4 2 0", acc_cnt, carry_cnt, out_valid);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
    repeat (17) @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (acc_cnt !== 4'd15 || carry_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL sat: acc=%0d carry=%0d want 15 2", acc_cnt, carry_cnt);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clr_cnt = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr_cnt = 1'b0;
    n_tests++;
    if (acc_cnt !== 4'd1 || carry_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_accept: acc=%0d carry=%0d want 1 1", acc_cnt, carry_cnt);
    end
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    n_tests++;
    if (acc_cnt !== 4'd0 || carry_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_idle: acc=%0d carry=%0d want 0 0", acc_cnt, carry_cnt);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || acc_cnt !== 4'd0 || carry_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b acc=%0d carry=%0d in_ready=%b want 0 0 0 1",
               out_valid, acc_cnt, carry_cnt, in_ready);
    end
  endtask

  task automatic test_width4();
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b1010; in_valid4 = 1'b1; out_ready4 = 1'b1;
    #1;
    n_tests++;
    if (s4 !== 4'b0110 || c4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL w4_comb: s=%b c=%b want 0110 1000", s4, c4);
    end
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0100;
    n_tests++;
    if (s_q4 !== 4'b0110 || c_q4 !== 4'b1000 || carry_cnt4 !== 16'd1 || acc_cnt4 !== 16'd1) begin
      n_fail++;
      $display("FAIL w4_carry: s_q=%b c_q=%b acc=%0d carry=%0d want 0110 1000 1 1", s_q4, c_q4, acc_cnt4, carry_cnt4);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    n_tests++;
    if (s_q4 !== 4'b0111 || c_q4 !== 4'b0000 || carry_cnt4 !== 16'd1 || acc_cnt4 !== 16'd2) begin
      n_fail++;
      $display("FAIL w4_nocarry: s_q=%b c_q=%b acc=%0d carry=%0d want 0111 0000 2 1", s_q4, c_q4, acc_cnt4, carry_cnt4);
    end
  endtask

  initial begin
    test_comb_sweep();
    test_reset();
    test_registered();
    test_backpressure();
    test_saturation();
    test_clear();
    test_mid_reset();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
